byte_serializer: RTL and testbench
==================================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter: BYTE_COUNT, default 6, number of bytes sent per frame; legal range 1..6.
REQ-002 i_Clk  input  1  single clock; all logic on the rising edge.
REQ-003 i_Rst_L  input  1  reset, synchronous and active-low.
REQ-004 i_Data  input  48  frame word; byte k is i_Data[8k+7:8k].
REQ-005 i_Load  input  1  start strobe; i_Data is captured on a cycle with i_Load=1 in IDLE.
REQ-006 i_Ready  input  1  sink accepts o_Data on a cycle where o_Valid=1 and i_Ready=1.
REQ-007 o_Data  output  8  byte currently offered.
REQ-008 o_Addr  output  3  byte index of o_Data, range 0..BYTE_COUNT-1 (BYTE_COUNT for checksum).
REQ-009 o_Valid  output  1  o_Data/o_Addr hold a valid byte.
REQ-010 o_Busy  output  1  high from the cycle after capture until the cycle o_Done pulses, inclusive.
REQ-011 o_Done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-012 The block SHALL implement states IDLE, SEND, CSUM (present only with the macro) and DONE.
REQ-013 IDLE with i_Load=1 SHALL latch i_Data into an internal 48-bit shadow register, clear the byte index to 0, and enter SEND.
REQ-014 In SEND, o_Valid SHALL be 1, o_Addr SHALL equal the index, and o_Data SHALL equal shadow byte[index], all registered outputs.
REQ-015 First o_Valid SHALL appear exactly one cycle after the capturing i_Load edge.
REQ-016 o_Data, o_Addr and o_Valid SHALL stay stable while i_Ready=0; there is no timeout.
REQ-017 On acceptance with index < BYTE_COUNT-1, the index SHALL increment and the next byte SHALL be presented the following cycle with no gap; a continuous i_Ready=1 yields one byte per cycle.
REQ-018 On acceptance with index = BYTE_COUNT-1, the FSM SHALL go to CSUM if compiled in, otherwise to DONE.
REQ-019 DONE SHALL last exactly one cycle with o_Done=1 and o_Valid=0, then return to IDLE.
REQ-020 i_Load outside IDLE SHALL be ignored, including in DONE; the shadow register is not overwritten mid-frame.
REQ-021 i_Ready outside SEND/CSUM SHALL have no effect.
REQ-022 Bytes SHALL be sent LSB-first: byte 0 (i_Data[7:0]) first, byte BYTE_COUNT-1 last; bytes above BYTE_COUNT-1 are never sent.
REQ-023 A frame SHALL therefore take BYTE_COUNT cycles (plus one with the checksum) plus one DONE cycle at minimum; the next i_Load is accepted the cycle after DONE.

Reset
REQ-024 While i_Rst_L=0 at a clock edge, the FSM SHALL enter IDLE and clear o_Data, o_Addr, o_Valid, o_Busy, o_Done, the index, the shadow register and the checksum accumulator to 0.
REQ-025 Reset in mid-frame SHALL abandon the frame with no o_Done pulse; the first byte after reset requires a new i_Load.
REQ-026 i_Load asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-027 Macro SERIALIZER_CHECKSUM_EN, when defined, SHALL enable the CSUM state.
- In CSUM, o_Data is the XOR of all BYTE_COUNT sent bytes, o_Addr = BYTE_COUNT, o_Valid=1, and the same handshake as REQ-016 applies.
- Acceptance in CSUM goes to DONE.
REQ-028 When SERIALIZER_CHECKSUM_EN is undefined, no checksum logic or state SHALL exist, and SEND goes directly to DONE.

Verification
REQ-029 Reset, i_Data=48'h665544332211, i_Load for 1 cycle, i_Ready=1 constant -> bytes 11,22,33,44,55,66 on addr 0..5 on consecutive cycles, o_Done pulses on the next cycle.
REQ-030 Same frame, i_Ready low 3 cycles at addr 2 -> byte 33 at addr 2 held stable for 4 cycles, then sequence resumes with no bytes lost or repeated.
REQ-031 i_Load with i_Data=48'hFFFFFFFFFFFF pulsed at addr 3 of an ongoing frame -> remaining bytes still come from the original word, no new frame is started.
REQ-032 i_Rst_L=0 for 1 cycle at addr 4 -> all outputs 0 next cycle, no o_Done; a fresh i_Load restarts at addr 0.
REQ-033 With SERIALIZER_CHECKSUM_EN and i_Data=48'h665544332211 -> addr 6 byte = 8'h77 (XOR of 11..66) before o_Done.
REQ-034 BYTE_COUNT=1 with i_Data=48'h0000000000A5 -> single byte A5 at addr 0, o_Done one cycle after acceptance.

Source files
------------

// File: rtl/byte_serializer_if.sv
// ---------------------------------------------------------------------------
// byte_serializer_if
// Purpose : Groups the frame-load and byte-stream handshake signals of
//           byte_serializer so the design and its environment share one bundle.
// Signals : i_Data  [47:0] frame word, byte k is i_Data[8k+7:8k]
//           i_Load         start strobe, honoured only while the serializer idles
//           i_Ready        sink accepts the offered byte when o_Valid is also high
//           o_Data  [7:0]  byte currently offered
//           o_Addr  [2:0]  index of the offered byte (BYTE_COUNT for the checksum)
//           o_Valid        o_Data/o_Addr hold a valid byte
//           o_Busy         frame in progress, up to and including the o_Done cycle
//           o_Done         one-cycle pulse after the last byte is accepted
// Modports: slave  - seen by the serializer
//           master - seen by whatever drives the serializer
// ---------------------------------------------------------------------------
interface byte_serializer_if;
  logic [47:0] i_Data;
  logic        i_Load;
  logic        i_Ready;
  logic [7:0]  o_Data;
  logic [2:0]  o_Addr;
  logic        o_Valid;
  logic        o_Busy;
  logic        o_Done;

  modport slave (
    input  i_Data, i_Load, i_Ready,
    output o_Data, o_Addr, o_Valid, o_Busy, o_Done
  );

  modport master (
    output i_Data, i_Load, i_Ready,
    input  o_Data, o_Addr, o_Valid, o_Busy, o_Done
  );
endinterface

// File: rtl/byte_serializer.sv
// ---------------------------------------------------------------------------
// byte_serializer
// Purpose : Captures a 48-bit word on i_Load and streams its low BYTE_COUNT
//           bytes LSB-first over a valid/ready handshake, then pulses o_Done.
//           Defining SERIALIZER_CHECKSUM_EN appends one extra byte, the XOR of
//           all sent bytes, presented at address BYTE_COUNT before o_Done.
// Params  : BYTE_COUNT - bytes per frame, 1..6 (default 6)
// Ports   : i_Clk   - clock, rising edge
//           i_Rst_L - synchronous active-low reset
//           bus     - byte_serializer_if.slave (load, data and handshake)
// ---------------------------------------------------------------------------
module byte_serializer #(
  parameter int BYTE_COUNT = 6
) (
  input logic            i_Clk,
  input logic            i_Rst_L,
  byte_serializer_if.slave bus
);

  localparam logic [2:0] LAST_IDX = 3'(BYTE_COUNT - 1);

`ifdef SERIALIZER_CHECKSUM_EN
  localparam logic [2:0] CSUM_ADDR = 3'(BYTE_COUNT);
  typedef enum logic [1:0] {IDLE, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [2:0]  byteIdx_q, byteIdx_d;
  logic [47:0] shadow_q, shadow_d;
`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif
  logic [7:0]  data_q, data_d;
  logic [2:0]  addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [7:0] byteAt(input logic [47:0] word, input logic [2:0] idx);
    return 8'(word >> {idx, 3'b000});
  endfunction

  // Next-state logic. The outputs are derived from the *next* state and index
  // so they can be registered and still line up with the state they describe;
  // this is what makes the first byte appear one cycle after the load edge.
  always_comb begin
    state_d   = state_q;
    byteIdx_d = byteIdx_q;
    shadow_d  = shadow_q;
`ifdef SERIALIZER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.i_Load) begin
          shadow_d  = bus.i_Data;
          byteIdx_d = 3'd0;
`ifdef SERIALIZER_CHECKSUM_EN
          csum_d    = 8'd0;
`endif
          state_d   = SEND;
        end
      end
      SEND: begin
        if (bus.i_Ready) begin
`ifdef SERIALIZER_CHECKSUM_EN
          csum_d = csum_q ^ byteAt(shadow_q, byteIdx_q);
`endif
          if (byteIdx_q == LAST_IDX) begin
`ifdef SERIALIZER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            byteIdx_d = byteIdx_q + 3'd1;
          end
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      CSUM: begin
        if (bus.i_Ready) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = 1'b0;
    data_d  = 8'd0;
    addr_d  = 3'd0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    if (state_d == SEND) begin
      valid_d = 1'b1;
      data_d  = byteAt(shadow_d, byteIdx_d);
      addr_d  = byteIdx_d;
    end
`ifdef SERIALIZER_CHECKSUM_EN
    if (state_d == CSUM) begin
      valid_d = 1'b1;
      data_d  = csum_d;
      addr_d  = CSUM_ADDR;
    end
`endif
  end

  // State and output registers. Reset takes priority over everything,
  // so a load strobe coinciding with reset is dropped.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      byteIdx_q <= 3'd0;
      shadow_q  <= 48'd0;
`ifdef SERIALIZER_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
      data_q    <= 8'd0;
      addr_q    <= 3'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      byteIdx_q <= byteIdx_d;
      shadow_q  <= shadow_d;
`ifdef SERIALIZER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
      data_q    <= data_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_Data  = data_q;
  assign bus.o_Addr  = addr_q;
  assign bus.o_Valid = valid_q;
  assign bus.o_Busy  = busy_q;
  assign bus.o_Done  = done_q;

endmodule

// File: tb/tb_byte_serializer.sv
// ---------------------------------------------------------------------------
// tb_byte_serializer
// Purpose : Drives a 6-byte and a 1-byte serializer and compares every offered
//           byte against the expected stream derived from the captured word.
//           Follows SERIALIZER_CHECKSUM_EN so the checksum byte is expected
//           only when the design is built with it.
// ---------------------------------------------------------------------------
module tb_byte_serializer;

  localparam int BC = 6;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int CSUM_EN = 1;
`else
  localparam int CSUM_EN = 0;
`endif

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  byte_serializer_if bus6();
  byte_serializer_if bus1();

  byte_serializer #(.BYTE_COUNT(BC)) dut6 (
    .i_Clk   (clk),
    .i_Rst_L (rstN),
    .bus     (bus6)
  );

  byte_serializer #(.BYTE_COUNT(1)) dut1 (
    .i_Clk   (clk),
    .i_Rst_L (rstN),
    .bus     (bus1)
  );

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one complete frame on the 6-byte instance. Entered and left on a
  // falling edge with the serializer idle. The expected stream is the list of
  // low bytes of the word (plus their XOR when the checksum is built in);
  // each byte must stay on the outputs until a cycle with ready high.
  task automatic applyStimulus(input logic [47:0] word, input int stallPct,
                               input int stallAt, input bit strayLoad);
    logic [7:0] expByte[$];
    logic [2:0] expAddr[$];
    logic [7:0] xsum;
    int cycles;
    int stalls;
    int held;
    bit rdy;
    xsum = 8'd0;
    cycles = 0;
    stalls = 0;
    held = 0;
    for (int k = 0; k < BC; k++) begin
      expByte.push_back(8'(word >> (8 * k)));
      expAddr.push_back(3'(k));
      xsum = xsum ^ 8'(word >> (8 * k));
    end
    if (CSUM_EN != 0) begin
      expByte.push_back(xsum);
      expAddr.push_back(3'(BC));
    end

    checkOutput("busyBeforeCapture", 64'(bus6.o_Busy), 64'd0);
    bus6.i_Data  = word;
    bus6.i_Load  = 1'b1;
    bus6.i_Ready = 1'($urandom);
    @(negedge clk);
    bus6.i_Load = 1'b0;

    while (expByte.size() > 0 && cycles < 100) begin
      checkOutput("valid", 64'(bus6.o_Valid), 64'd1);
      checkOutput("data",  64'(bus6.o_Data),  64'(expByte[0]));
      checkOutput("addr",  64'(bus6.o_Addr),  64'(expAddr[0]));
      checkOutput("busy",  64'(bus6.o_Busy),  64'd1);
      checkOutput("doneEarly", 64'(bus6.o_Done), 64'd0);
      if (stallAt >= 0) begin
        rdy = !(int'(expAddr[0]) == stallAt && held < 3);
      end else begin
        rdy = ($urandom_range(99) >= stallPct);
      end
      if (!rdy) begin
        stalls++;
        held++;
      end
      bus6.i_Ready = rdy;
      if (strayLoad && expAddr[0] == 3'd3) begin
        bus6.i_Load = 1'b1;
        bus6.i_Data = 48'hFFFFFFFFFFFF;
      end else begin
        bus6.i_Load = 1'b0;
      end
      if (rdy) begin
        void'(expByte.pop_front());
        void'(expAddr.pop_front());
      end
      @(negedge clk);
      cycles++;
    end

    checkOutput("frameCycles", 64'(cycles), 64'(BC + CSUM_EN + stalls));
    bus6.i_Load  = 1'b0;
    bus6.i_Ready = 1'($urandom);
    checkOutput("doneHigh",   64'(bus6.o_Done),  64'd1);
    checkOutput("doneValid",  64'(bus6.o_Valid), 64'd0);
    checkOutput("doneBusy",   64'(bus6.o_Busy),  64'd1);
    if (strayLoad) begin
      bus6.i_Load = 1'b1;
      bus6.i_Data = ~word;
    end
    @(negedge clk);
    bus6.i_Load = 1'b0;
    checkOutput("doneOnce",   64'(bus6.o_Done),  64'd0);
    checkOutput("idleValid",  64'(bus6.o_Valid), 64'd0);
    checkOutput("idleBusy",   64'(bus6.o_Busy),  64'd0);
  endtask

  initial begin
    logic [47:0] word;

    bus6.i_Data  = 48'd0;
    bus6.i_Load  = 1'b1;
    bus6.i_Ready = 1'b1;
    bus1.i_Data  = 48'd0;
    bus1.i_Load  = 1'b0;
    bus1.i_Ready = 1'b0;

    // Reset with a load strobe pending: nothing may start.
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstValid", 64'(bus6.o_Valid), 64'd0);
    checkOutput("rstData",  64'(bus6.o_Data),  64'd0);
    checkOutput("rstAddr",  64'(bus6.o_Addr),  64'd0);
    checkOutput("rstBusy",  64'(bus6.o_Busy),  64'd0);
    checkOutput("rstDone",  64'(bus6.o_Done),  64'd0);
    checkOutput("rstValid1", 64'(bus1.o_Valid), 64'd0);
    bus6.i_Load = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("noStartAfterRst", 64'(bus6.o_Valid), 64'd0);

    // Single-byte instance.
    bus1.i_Data  = 48'h0000000000A5;
    bus1.i_Load  = 1'b1;
    bus1.i_Ready = 1'b1;
    @(negedge clk);
    bus1.i_Load = 1'b0;
    checkOutput("bc1Valid", 64'(bus1.o_Valid), 64'd1);
    checkOutput("bc1Data",  64'(bus1.o_Data),  64'hA5);
    checkOutput("bc1Addr",  64'(bus1.o_Addr),  64'd0);
    @(negedge clk);
    if (CSUM_EN != 0) begin
      checkOutput("bc1CsumData", 64'(bus1.o_Data), 64'hA5);
      checkOutput("bc1CsumAddr", 64'(bus1.o_Addr), 64'd1);
      @(negedge clk);
    end
    checkOutput("bc1Done",      64'(bus1.o_Done),  64'd1);
    checkOutput("bc1DoneValid", 64'(bus1.o_Valid), 64'd0);
    @(negedge clk);
    checkOutput("bc1DoneOnce",  64'(bus1.o_Done),  64'd0);
    bus1.i_Ready = 1'b0;

    // Directed frames: continuous ready, stall at addr 2, stray load at addr 3.
    applyStimulus(48'h665544332211, 0, -1, 1'b0);
    applyStimulus(48'h665544332211, 0, 2, 1'b0);
    applyStimulus(48'h665544332211, 0, -1, 1'b1);

    // Reset in mid-frame at addr 4, with a load strobe during reset.
    bus6.i_Data  = 48'h665544332211;
    bus6.i_Load  = 1'b1;
    bus6.i_Ready = 1'b1;
    @(negedge clk);
    bus6.i_Load = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("preRstAddr", 64'(bus6.o_Addr), 64'd4);
    rstN = 1'b0;
    bus6.i_Load = 1'b1;
    @(negedge clk);
    checkOutput("midRstValid", 64'(bus6.o_Valid), 64'd0);
    checkOutput("midRstData",  64'(bus6.o_Data),  64'd0);
    checkOutput("midRstAddr",  64'(bus6.o_Addr),  64'd0);
    checkOutput("midRstBusy",  64'(bus6.o_Busy),  64'd0);
    checkOutput("midRstDone",  64'(bus6.o_Done),  64'd0);
    rstN = 1'b1;
    bus6.i_Load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("postRstValid", 64'(bus6.o_Valid), 64'd0);
      checkOutput("postRstDone",  64'(bus6.o_Done),  64'd0);
    end
    applyStimulus(48'h665544332211, 0, -1, 1'b0);

    // Random words with random backpressure and stray loads.
    for (int f = 0; f < 10; f++) begin
      word = {16'($urandom), 32'($urandom)};
      applyStimulus(word, 35, -1, 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
